core_sequencer: RTL
===================

# core_sequencer

Multi-cycle control sequencer for the RV32I core datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath's enables and the program-counter mux select. It handshakes with instruction and data memory, halts on SYSTEM or illegal opcodes and on memory timeouts, and counts retired instructions. It sits beside the decode unit and replaces the fixed `PCSel = 00` / free-running PC update in the top level.

## Interface
- `TIMEOUT`, default 16: cycles to wait for `imem_ready`/`dmem_ready` before declaring a fault (≥2).
- `COUNT_W`, default 32: width of the retire counter.
- `clk` in 1: core clock, rising edge.
- `reset_l` in 1: asynchronous, active-low reset.
- `run` in 1: start/continue execution; sampled in IDLE and at end of WB.
- `opcode` in 7: instr[6:0] from the decode unit; valid from DECODE onward.
- `branch_taken` in 1: branch comparison result; valid in EXECUTE and WB.
- `imem_ready` in 1: instruction memory data valid.
- `dmem_ready` in 1: data memory access complete.
- `imem_req` out 1: instruction fetch request.
- `ir_we` out 1: instruction-register load strobe.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write (stores).
- `rf_we` out 1: register-file write strobe.
- `pc_we` out 1: PC register load strobe.
- `pc_sel` out 2: PC mux select. 00 = pc+4, 01 = pc+imm (branch taken / JAL), 10 = rs1+imm (JALR), 11 = reserved, never driven.
- `halted` out 1: sticky halt indication.
- `fault` out 1: sticky; set when halt was caused by a memory timeout.
- `retire_count` out COUNT_W: instructions retired.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- IDLE: `run`=1 → FETCH, otherwise stay.
- FETCH:
  - `imem_req`=1 throughout the state.
  - When `imem_ready`=1: `ir_we`=1 in the same cycle (Mealy) → DECODE.
- DECODE: one cycle.
  - `opcode` = SYSTEM (1110011) or any opcode outside the RV32I base set → HALT.
  - Otherwise → EXECUTE.
- EXECUTE: one cycle.
  - LOAD (0000011) or STORE (0100011) → MEM.
  - Otherwise → WB.
- MEM:
  - `dmem_req`=1 throughout; `dmem_we`=1 when the opcode is STORE.
  - When `dmem_ready`=1 → WB.
- WB: one cycle.
  - `pc_we`=1.
  - `rf_we`=1 unless the opcode is STORE or BRANCH.
  - `pc_sel`: BRANCH → 01 if `branch_taken`, else 00; JAL → 01; JALR → 10; everything else → 00.
  - `retire_count` increments by 1 and wraps modulo 2^COUNT_W.
  - Next state is FETCH if `run`=1, otherwise IDLE.
- Watchdog:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle the ready input is low.
  - When the counter reaches TIMEOUT-1 with ready still low: → HALT and `fault` is set.
  - A ready arriving in that same cycle wins; no fault is raised.
- HALT:
  - All strobes are 0 and `halted`=1.
  - HALT is left only by reset; `run` is ignored.
- Outside the states listed above, every strobe is 0 and `pc_sel`=00.
- `ready` inputs asserted outside their wait state are ignored.

## Timing
- Reset (asynchronous assert): state goes to IDLE. Every output is 0, including `retire_count`, `halted` and `fault`. This applies mid-instruction as well; any outstanding request is dropped the same instant.
- Deassertion of `reset_l` is synchronised externally. The first active edge afterwards samples `run`.
- Minimum instruction latency with zero-wait memory:
  - ALU, branch or jump: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Load or store: 5 cycles.
- Each cycle of memory wait adds exactly one cycle.
- All outputs except `ir_we` are decoded from registered state, so they are glitch-free.
- `run` dropping mid-instruction takes effect only at the end of WB. The current instruction always retires.

## Structure
- Shared package `core_pkg`:
  - opcode constants (LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC, SYSTEM, MISC_MEM),
  - `seq_state_t` enum,
  - `pc_sel` encodings, shared with the top-level PC mux.
- Single module, no sub-modules. The watchdog counter is `$clog2(TIMEOUT)` bits wide and is built inline.

## Test plan
- Reset, then `run`=1, with zero-wait memory and opcode OP (0110011) repeated → one `pc_we`/`rf_we` pair every 4 cycles, `pc_sel`=00; `retire_count`=3 after 12 cycles.
- STORE with `dmem_ready` delayed 3 cycles → `dmem_req`=`dmem_we`=1 for 4 cycles, `rf_we`=0 in WB, instruction takes 8 cycles.
- BRANCH with `branch_taken`=1, then with 0 → WB `pc_sel`=01, then 00; `rf_we`=0 both times. JALR → `pc_sel`=10 with `rf_we`=1.
- `imem_ready` held low with TIMEOUT=16 → `imem_req` stays high for 16 cycles, then `halted`=`fault`=1. Later `run` toggles produce no strobes until reset.
- Opcode 1110011 and illegal opcode 1111111 → HALT after DECODE, `fault`=0, `retire_count` unchanged.
- Assert `reset_l`=0 during MEM → `dmem_req` drops immediately and all outputs read 0. `run` low at WB → IDLE, and a later `run`=1 restarts at FETCH.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: opcodes, sequencer states, PC mux selects.
package core_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

  localparam int unsigned PC_SEL_W = 2;

  localparam logic [PC_SEL_W-1:0] PC_SEL_PLUS4   = 2'b00;
  localparam logic [PC_SEL_W-1:0] PC_SEL_PC_IMM  = 2'b01;
  localparam logic [PC_SEL_W-1:0] PC_SEL_RS1_IMM = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } seq_state_t;

  // Opcodes the sequencer will execute; SYSTEM is deliberately excluded so it halts.
  function automatic logic is_exec_op(input logic [OPC_W-1:0] op);
    case (op)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
      OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory
// watchdog, sticky halt/fault and retire counter.
// Ports:
//   clk, reset_l            : clock, async active-low reset
//   run                     : start/continue, sampled in IDLE and WB
//   opcode, branch_taken    : from decode unit / branch comparator
//   imem_ready, dmem_ready  : memory handshakes
//   imem_req, ir_we         : fetch request, IR load (ir_we is Mealy on imem_ready)
//   dmem_req, dmem_we       : data access request / write
//   rf_we, pc_we, pc_sel    : writeback strobes and PC mux select
//   halted, fault           : sticky status
//   retire_count            : retired instruction count (wraps)
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned COUNT_W = 32
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic                run,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                branch_taken,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_we,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                rf_we,
  output logic                pc_we,
  output logic [PC_SEL_W-1:0] pc_sel,
  output logic                halted,
  output logic                fault,
  output logic [COUNT_W-1:0]  retire_count
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  seq_state_t          state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                is_store;
  logic                is_mem;
  logic                wb_rf_we;
  logic [PC_SEL_W-1:0] wb_pc_sel;

  // Opcode-derived controls; outputs are registered on the edge entering each state.
  always_comb begin
    is_store  = (opcode == OPC_STORE);
    is_mem    = (opcode == OPC_LOAD) || is_store;
    wb_rf_we  = !(is_store || (opcode == OPC_BRANCH));
    wb_pc_sel = PC_SEL_PLUS4;
    if (opcode == OPC_JAL || (opcode == OPC_BRANCH && branch_taken)) begin
      wb_pc_sel = PC_SEL_PC_IMM;
    end else if (opcode == OPC_JALR) begin
      wb_pc_sel = PC_SEL_RS1_IMM;
    end
  end

  assign ir_we = (state == S_FETCH) && imem_ready;

  // Sequencer FSM with registered strobes, watchdog and retire counter.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      imem_req     <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      rf_we        <= 1'b0;
      pc_we        <= 1'b0;
      pc_sel       <= PC_SEL_PLUS4;
      halted       <= 1'b0;
      fault        <= 1'b0;
      retire_count <= '0;
    end else begin
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      pc_we    <= 1'b0;
      pc_sel   <= PC_SEL_PLUS4;
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            state  <= S_HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          if (is_exec_op(opcode)) begin
            state <= S_EXECUTE;
          end else begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_EXECUTE: begin
          if (is_mem) begin
            state    <= S_MEM;
            dmem_req <= 1'b1;
            dmem_we  <= is_store;
            wait_cnt <= '0;
          end else begin
            state        <= S_WB;
            pc_we        <= 1'b1;
            rf_we        <= wb_rf_we;
            pc_sel       <= wb_pc_sel;
            retire_count <= retire_count + COUNT_W'(1);
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state        <= S_WB;
            pc_we        <= 1'b1;
            rf_we        <= wb_rf_we;
            pc_sel       <= wb_pc_sel;
            retire_count <= retire_count + COUNT_W'(1);
          end else if (wait_cnt == WAIT_LAST) begin
            state  <= S_HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            dmem_req <= 1'b1;
            dmem_we  <= is_store;
          end
        end
        S_WB: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
